// File: rtl/vram_slot_arbiter.sv
// Time-multiplexes one synchronous-read vram across N_LAYERS requesters, one read per layer per pixel period.
// A batch is presented on layer_data_o one clk after the pix_tick that closes it, so a full-rate final word can still land.
module vram_slot_arbiter #(
  parameter int unsigned N_LAYERS = 4,
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned DATA_W   = 13,
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pix_tick_i,
  input  logic [N_LAYERS*ADDR_W-1:0]   req_addr_i,
  input  logic [N_LAYERS-1:0]          req_en_i,
  output logic [ADDR_W-1:0]            vram_addr_o,
  output logic                         vram_en_o,
  input  logic [DATA_W-1:0]            vram_data_i,
  output logic [N_LAYERS*DATA_W-1:0]   layer_data_o,
  output logic [N_LAYERS-1:0]          layer_valid_o,
  output logic                         out_strobe_o,
  output logic                         overrun_o
);

  localparam int unsigned IDX_W     = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam int unsigned BATCH_CYC = N_LAYERS + READ_LAT - 1;
  localparam int unsigned CNT_W     = $clog2(BATCH_CYC + SLOTS + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
  typedef logic [N_LAYERS-1:0][ADDR_W-1:0] addr_vec_t;
  typedef logic [N_LAYERS-1:0][DATA_W-1:0] data_vec_t;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                slot_q, slot_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  addr_vec_t                       snap_addr_q, snap_addr_d;
  logic [N_LAYERS-1:0]             snap_en_q, snap_en_d;
  logic [ADDR_W-1:0]               vram_addr_q, vram_addr_d;
  logic                            vram_en_q, vram_en_d;
  logic [READ_LAT:0]               cap_vld_q, cap_vld_d;
  logic [READ_LAT:0]               cap_en_q, cap_en_d;
  logic [READ_LAT:0][IDX_W-1:0]    cap_idx_q, cap_idx_d;
  data_vec_t                       shadow_q, shadow_d;
  logic                            xfer_q, xfer_d;
  logic [N_LAYERS-1:0]             xfer_en_q, xfer_en_d;
  data_vec_t                       layer_data_q, layer_data_d;
  logic [N_LAYERS-1:0]             layer_valid_q, layer_valid_d;
  logic                            strobe_q, strobe_d;
  logic                            overrun_q, overrun_d;

  logic                            tick_ok;
  logic                            tick_ovr;
  logic                            issue_vld;
  logic                            issue_en;
  logic [IDX_W-1:0]                issue_idx;

  // A tick is on time when at most the final capture of the batch is still outstanding.
  always_comb begin
    tick_ok  = pix_tick_i && ((state_q == DONE) || ((state_q == DRAIN) && (cnt_q <= CNT_W'(1))));
    tick_ovr = pix_tick_i && !tick_ok && (state_q != IDLE);
  end

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    cnt_d         = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
    snap_addr_d   = snap_addr_q;
    snap_en_d     = snap_en_q;
    vram_addr_d   = vram_addr_q;
    vram_en_d     = 1'b0;
    shadow_d      = shadow_q;
    xfer_d        = 1'b0;
    xfer_en_d     = xfer_en_q;
    layer_data_d  = layer_data_q;
    layer_valid_d = layer_valid_q;
    strobe_d      = 1'b0;
    overrun_d     = overrun_q;
    issue_vld     = 1'b0;
    issue_en      = 1'b0;
    issue_idx     = '0;

    // Capture; words of a discarded batch are dropped.
    if (cap_vld_q[READ_LAT] && !tick_ovr) begin
      shadow_d[cap_idx_q[READ_LAT]] = cap_en_q[READ_LAT] ? vram_data_i : '0;
    end

    // Atomic transfer uses shadow_d so a word landing this cycle is included.
    if (xfer_q) begin
      layer_data_d  = shadow_d;
      layer_valid_d = xfer_en_q;
      strobe_d      = 1'b1;
    end

    case (state_q)
      ISSUE: begin
        issue_vld   = 1'b1;
        issue_idx   = slot_q;
        issue_en    = snap_en_q[slot_q];
        vram_addr_d = snap_addr_q[slot_q];
        if (slot_q == IDX_W'(N_LAYERS - 1)) begin
          state_d = DRAIN;
        end else begin
          slot_d = slot_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      default: ;
    endcase

    if (pix_tick_i) begin
      if (tick_ok) begin
        xfer_d    = 1'b1;
        xfer_en_d = snap_en_q;
      end
      if (tick_ovr) begin
        overrun_d = 1'b1;
      end
      snap_addr_d = addr_vec_t'(req_addr_i);
      snap_en_d   = req_en_i;
      issue_vld   = 1'b1;
      issue_idx   = '0;
      issue_en    = req_en_i[0];
      vram_addr_d = req_addr_i[ADDR_W-1:0];
      slot_d      = IDX_W'(1);
      cnt_d       = CNT_W'(BATCH_CYC);
      state_d     = (N_LAYERS > 1) ? ISSUE : DRAIN;
    end

    vram_en_d = issue_vld & issue_en;

    // Read-return pipeline tracks which slot each returning word belongs to.
    cap_vld_d[0] = issue_vld;
    cap_en_d[0]  = issue_en;
    cap_idx_d[0] = issue_idx;
    for (int k = 1; k <= int'(READ_LAT); k++) begin
      cap_vld_d[k] = cap_vld_q[k-1] & ~tick_ovr;
      cap_en_d[k]  = cap_en_q[k-1];
      cap_idx_d[k] = cap_idx_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      cnt_q         <= '0;
      snap_addr_q   <= '0;
      snap_en_q     <= '0;
      vram_addr_q   <= '0;
      vram_en_q     <= 1'b0;
      cap_vld_q     <= '0;
      cap_en_q      <= '0;
      cap_idx_q     <= '0;
      shadow_q      <= '0;
      xfer_q        <= 1'b0;
      xfer_en_q     <= '0;
      layer_data_q  <= '0;
      layer_valid_q <= '0;
      strobe_q      <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      cnt_q         <= cnt_d;
      snap_addr_q   <= snap_addr_d;
      snap_en_q     <= snap_en_d;
      vram_addr_q   <= vram_addr_d;
      vram_en_q     <= vram_en_d;
      cap_vld_q     <= cap_vld_d;
      cap_en_q      <= cap_en_d;
      cap_idx_q     <= cap_idx_d;
      shadow_q      <= shadow_d;
      xfer_q        <= xfer_d;
      xfer_en_q     <= xfer_en_d;
      layer_data_q  <= layer_data_d;
      layer_valid_q <= layer_valid_d;
      strobe_q      <= strobe_d;
      overrun_q     <= overrun_d;
    end
  end

  assign vram_addr_o   = vram_addr_q;
  assign vram_en_o     = vram_en_q;
  assign layer_data_o  = layer_data_q;
  assign layer_valid_o = layer_valid_q;
  assign out_strobe_o  = strobe_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Bench for vram_slot_arbiter: behavioural vram plus a per-pixel reference model of snapshot, issue order and presentation.
module tb_vram_slot_arbiter;

  localparam int unsigned N      = 4;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 13;
  localparam int unsigned SLOTS  = 4;
  localparam int unsigned RLAT   = 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  pix_tick;
  logic [N*ADDR_W-1:0]   req_addr;
  logic [N-1:0]          req_en;
  logic [ADDR_W-1:0]     vram_addr;
  logic                  vram_en;
  logic [DATA_W-1:0]     vram_data = '0;
  logic [N*DATA_W-1:0]   layer_data;
  logic [N-1:0]          layer_valid;
  logic                  out_strobe;
  logic                  overrun;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [N*DATA_W-1:0]   exp_data;
  logic [N-1:0]          exp_valid;
  logic                  exp_strobe;
  logic                  exp_ovr;
  logic                  exp_en;
  logic [ADDR_W-1:0]     exp_addr;
  logic [N*ADDR_W-1:0]   m_snap_addr;
  logic [N-1:0]          m_snap_en;
  logic                  have_batch;
  logic                  xfer_pend;
  logic [N*DATA_W-1:0]   xfer_data;
  logic [N-1:0]          xfer_valid;
  int                    iss_k;
  int                    gap;

  always #5 clk = ~clk;

  vram_slot_arbiter #(
    .N_LAYERS(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SLOTS(SLOTS), .READ_LAT(RLAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_tick_i   (pix_tick),
    .req_addr_i   (req_addr),
    .req_en_i     (req_en),
    .vram_addr_o  (vram_addr),
    .vram_en_o    (vram_en),
    .vram_data_i  (vram_data),
    .layer_data_o (layer_data),
    .layer_valid_o(layer_valid),
    .out_strobe_o (out_strobe),
    .overrun_o    (overrun)
  );

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [31:0] t;
    t = (32'(a) * 32'd40503) ^ 32'h5A5A;
    return DATA_W'(t >> 3) | DATA_W'(1);
  endfunction

  // Single-port synchronous-read vram, one cycle latency
  always_ff @(posedge clk) begin
    if (vram_en) vram_data <= mem_word(vram_addr);
  end

  task automatic model_edge();
    exp_strobe = 1'b0;
    if (!rst_n) begin
      exp_data = '0; exp_valid = '0; exp_ovr = 1'b0; exp_en = 1'b0; exp_addr = '0;
      have_batch = 1'b0; xfer_pend = 1'b0; iss_k = N; gap = 0;
    end else begin
      if (xfer_pend) begin
        exp_data = xfer_data; exp_valid = xfer_valid; exp_strobe = 1'b1; xfer_pend = 1'b0;
      end
      if (gap < 1000) gap++;
      if (pix_tick) begin
        if (have_batch) begin
          if (gap >= int'(SLOTS)) begin
            xfer_pend  = 1'b1;
            xfer_valid = m_snap_en;
            for (int i = 0; i < int'(N); i++)
              xfer_data[i*DATA_W +: DATA_W] = m_snap_en[i] ? mem_word(m_snap_addr[i*ADDR_W +: ADDR_W]) : '0;
          end else begin
            exp_ovr = 1'b1;
          end
        end
        m_snap_addr = req_addr; m_snap_en = req_en; have_batch = 1'b1; gap = 0; iss_k = 0;
      end else if (iss_k < int'(N)) begin
        iss_k++;
      end
      if (iss_k < int'(N)) begin
        exp_en   = m_snap_en[iss_k];
        exp_addr = m_snap_addr[iss_k*ADDR_W +: ADDR_W];
      end else begin
        exp_en = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic cyc(input logic tick);
    pix_tick = tick;
    @(posedge clk);
    model_edge();
    #1;
    chk("out_strobe", 64'(out_strobe), 64'(exp_strobe));
    chk("overrun", 64'(overrun), 64'(exp_ovr));
    chk("vram_en", 64'(vram_en), 64'(exp_en));
    chk("vram_addr", 64'(vram_addr), 64'(exp_addr));
    chk("layer_data", 64'(layer_data), 64'(exp_data));
    chk("layer_valid", 64'(layer_valid), 64'(exp_valid));
    pix_tick = 1'b0;
  endtask

  // One pixel period: tick now, then gap-1 idle cycles with optional request churn
  task automatic period(input int g, input logic churn);
    cyc(1'b1);
    for (int c = 1; c < g; c++) begin
      if (churn) begin
        req_addr = {$urandom, $urandom};
        req_en   = N'($urandom);
      end
      cyc(1'b0);
    end
  endtask

  task automatic set_req_ramp(input int k, input logic [N-1:0] en);
    for (int i = 0; i < int'(N); i++) req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(100 * i + k);
    req_en = en;
  endtask

  initial begin
    rst_n = 1'b0; pix_tick = 1'b0; req_addr = '0; req_en = '0;
    exp_data = '0; exp_valid = '0; exp_strobe = 1'b0; exp_ovr = 1'b0; exp_en = 1'b0; exp_addr = '0;
    m_snap_addr = '0; m_snap_en = '0; have_batch = 1'b0; xfer_pend = 1'b0;
    xfer_data = '0; xfer_valid = '0; iss_k = N; gap = 0;

    cyc(1'b0); cyc(1'b0);
    rst_n = 1'b1;
    cyc(1'b0);

    // Full-rate ticks, all layers on, ramp addresses
    for (int k = 0; k < 6; k++) begin
      set_req_ramp(k, 4'b1111);
      period(SLOTS, 1'b0);
    end

    // Sparse enable
    for (int k = 6; k < 9; k++) begin
      set_req_ramp(k, 4'b0101);
      period(SLOTS, 1'b0);
    end

    // Requests changing between ticks must not leak into the batch
    for (int k = 9; k < 12; k++) begin
      set_req_ramp(k, 4'b1111);
      period(SLOTS, 1'b1);
    end

    // Early tick: overrun, then recovery
    set_req_ramp(20, 4'b1011);
    period(SLOTS, 1'b0);
    set_req_ramp(21, 4'b1111);
    period(2, 1'b0);
    for (int k = 22; k < 25; k++) begin
      set_req_ramp(k, 4'b1110);
      period(SLOTS, 1'b0);
    end

    // Reset while slot 2 is being issued
    set_req_ramp(30, 4'b1111);
    cyc(1'b1);
    cyc(1'b0);
    rst_n = 1'b0;
    cyc(1'b0);
    rst_n = 1'b1;
    cyc(1'b0);
    for (int k = 31; k < 34; k++) begin
      set_req_ramp(k, 4'b0111);
      period(SLOTS, 1'b0);
    end

    // Randomized traffic with occasional irregular tick spacing
    for (int p = 0; p < 150; p++) begin
      req_addr = {$urandom, $urandom};
      req_en   = N'($urandom);
      period(($urandom_range(0, 9) < 7) ? int'(SLOTS) : int'($urandom_range(2, 8)), 1'($urandom_range(0, 1)));
    end
    cyc(1'b0); cyc(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
